pipe_pal_fifo: RTL and testbench
================================

Name: pipe_pal_fifo

Overview:
Parametrised successor to the single-stage pipe block. It is a valid/ready buffered pipeline stage of configurable data width and depth. It decouples producer and consumer timing on datapaths, and it reports occupancy, almost-full and flush control. It sits between any two pipeline stages that need elastic buffering.

Parameters:
W_DATA, 32, data word width in bits (>=1)
DEPTH, 4, number of storage entries; power of two, >=2
AFULL_LVL, 3, o_afull asserts when occupancy >= AFULL_LVL (1..DEPTH)
W_ADDR (localparam), $clog2(DEPTH), pointer width

Ports:
i_clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
i_valid  input  1  producer word valid
o_ready  output  1  buffer can accept a word
i_data  input  W_DATA  producer data
o_valid  output  1  buffer holds a word for the consumer
i_ready  input  1  consumer accepts the word
o_data  output  W_DATA  head-of-buffer data
i_flush  input  1  synchronous discard of all contents
o_count  output  W_ADDR+1  current occupancy, 0..DEPTH
o_afull  output  1  occupancy >= AFULL_LVL

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert), values while asserted and on exit:
  - wr_ptr=0, rd_ptr=0, count=0
  - o_valid=0, o_ready=0 while reset is high; o_ready=1 the first cycle after release
  - o_count=0, o_afull=0, o_data=0
  - Storage array is not reset.
  - Reset asserted mid-transfer drops all contents immediately.
- Push = i_valid && o_ready. Pop = o_valid && i_ready. Both are evaluated on the same rising edge.
- o_ready = (count != DEPTH). There is no full-bypass: when full, a push is refused even if a pop occurs in the same cycle.
- o_valid = (count != 0). o_data = mem[rd_ptr] when o_valid, else forced to 0.
- Latency: a word pushed at edge N is visible on o_data/o_valid in the cycle after edge N. The minimum fall-through is 1 cycle, and there is no combinational i_data to o_data path.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Pointers increment modulo DEPTH on push (wr_ptr) and pop (rd_ptr). Wrap-around is natural binary rollover of W_ADDR bits.
- Order is strictly FIFO; no word is lost or duplicated across wrap.
- Flush: i_flush high at an edge sets wr_ptr=rd_ptr=count=0.
  - Flush has priority over push and pop in the same cycle; a concurrent push is discarded.
  - o_ready stays 1 during flush (count<DEPTH after flush), but the flush-cycle word is not stored.
- o_afull and o_count are registered-derived, with no combinational dependency on i_valid or i_ready.
- Producer protocol: i_data must be held stable while i_valid=1 && o_ready=0. The block does not check this.
- DEPTH not a power of two, or AFULL_LVL out of range: elaboration error via a generate-time check.

Optional Feature:
Macro PIPE_PAL_FIFO_PARITY_EN.
- Defined:
  - Each entry stores W_DATA+1 bits: data plus an even-parity bit computed on push.
  - Extra input i_perr_inject (1 bit) inverts the stored parity bit of the word pushed that cycle.
  - Extra output o_perr (1 bit, reset 0) = o_valid && (^o_data != stored parity), combinational from the head entry.
  - Data flow is unaffected.
- Undefined: no parity storage, and ports i_perr_inject and o_perr do not exist.

Test Plan:
- Reset release → next cycle o_ready=1, o_valid=0, o_count=0, o_data=0. Assert reset with 2 words stored → o_valid=0 and o_count=0 immediately, without a clock edge.
- DEPTH=4, AFULL_LVL=3, i_ready=0, push 0x11,0x22,0x33,0x44 → o_count 1,2,3,4; o_afull rises after the 3rd push; o_ready=0 after the 4th; a 5th push of 0x55 is refused.
- Full buffer, i_valid=1 and i_ready=1 in the same cycle → one pop of 0x11, push refused, o_count=3; the next cycle accepts 0x55.
- Stream 10 words 0x00..0x09 with random i_ready back-pressure (wraps pointers twice) → consumer receives 0x00..0x09 in order, with no gaps or repeats.
- Three words stored, then i_flush=1 with i_valid=1 (0xAA) → next cycle o_count=0, o_valid=0; 0xAA is never output.
- PIPE_PAL_FIFO_PARITY_EN defined: push 0x0F clean, then 0xF0 with i_perr_inject=1 → o_perr=0 while 0x0F is at the head, and o_perr=1 while 0xF0 is at the head.

Source files
------------

// File: rtl/pipe_pal_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pal_fifo
// Purpose  : Valid/ready elastic buffer with occupancy, almost-full and flush.
//            Optional parity on every entry when PIPE_PAL_FIFO_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_pal_fifo #(
    parameter int W_DATA    = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                    i_clk,
    input  logic                    reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [W_DATA-1:0]       i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [W_DATA-1:0]       o_data,
    input  logic                    i_flush,
`ifdef PIPE_PAL_FIFO_PARITY_EN
    input  logic                    i_perr_inject,
    output logic                    o_perr,
`endif
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_afull
);

    localparam int W_ADDR = $clog2(DEPTH);
`ifdef PIPE_PAL_FIFO_PARITY_EN
    localparam int W_ENTRY = W_DATA + 1;
`else
    localparam int W_ENTRY = W_DATA;
`endif
    localparam logic [W_ADDR:0]   c_depth   = (W_ADDR+1)'(DEPTH);
    localparam logic [W_ADDR:0]   c_afull   = (W_ADDR+1)'(AFULL_LVL);
    localparam logic [W_ADDR-1:0] c_ptr_one = W_ADDR'(1);
    localparam logic [W_ADDR:0]   c_cnt_one = (W_ADDR+1)'(1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("pipe_pal_fifo: DEPTH must be a power of two >= 2");
        end
        if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
            $error("pipe_pal_fifo: AFULL_LVL must lie in 1..DEPTH");
        end
    endgenerate

    logic [W_ENTRY-1:0] r_mem [DEPTH];
    logic [W_ADDR-1:0]  r_wr_ptr;
    logic [W_ADDR-1:0]  r_rd_ptr;
    logic [W_ADDR:0]    r_count;
    logic               r_rdy_en;

    logic               w_push;
    logic               w_pop;
    logic [W_ENTRY-1:0] w_entry_in;
    logic [W_ENTRY-1:0] w_head;

    // r_rdy_en holds o_ready low while reset is asserted and for the release edge
    assign o_ready = r_rdy_en && (r_count != c_depth);
    assign o_valid = (r_count != '0);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

`ifdef PIPE_PAL_FIFO_PARITY_EN
    assign w_entry_in = {(^i_data) ^ i_perr_inject, i_data};
`else
    assign w_entry_in = i_data;
`endif

    assign w_head  = r_mem[r_rd_ptr];
    assign o_data  = o_valid ? w_head[W_DATA-1:0] : '0;
    assign o_count = r_count;
    assign o_afull = (r_count >= c_afull);

`ifdef PIPE_PAL_FIFO_PARITY_EN
    assign o_perr = o_valid && ((^w_head[W_DATA-1:0]) != w_head[W_DATA]);
`endif

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= w_entry_in;
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_one;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_cnt_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_pal_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_pal_fifo
// Purpose  : Scoreboard bench for pipe_pal_fifo (DEPTH=4, AFULL_LVL=3, 8-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_pal_fifo;

    logic       i_clk;
    logic       reset;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       i_flush;
    logic [2:0] o_count;
    logic       o_afull;
`ifdef PIPE_PAL_FIFO_PARITY_EN
    logic       i_perr_inject;
    logic       o_perr;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    pipe_pal_fifo #(
        .W_DATA    (8),
        .DEPTH     (4),
        .AFULL_LVL (3)
    ) dut (
        .i_clk         (i_clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .i_flush       (i_flush),
`ifdef PIPE_PAL_FIFO_PARITY_EN
        .i_perr_inject (i_perr_inject),
        .o_perr        (o_perr),
`endif
        .o_count       (o_count),
        .o_afull       (o_afull)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever o_valid && i_ready mid-cycle
    always @(negedge i_clk) begin
        if (reset === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got 0x%0h, expected no output", o_data);
            end else begin
                chk("pop_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        int k;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (k = 0; k < 40 && o_count != 3'd0; k++) step();
        i_ready = 1'b0;
        chk("drain_count", {29'd0, o_count}, 32'd0);
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    logic [7:0] fill_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] fill_cnt  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       fill_af   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        i_data  = 8'h00;
`ifdef PIPE_PAL_FIFO_PARITY_EN
        i_perr_inject = 1'b0;
`endif
        repeat (2) step();
        chk("rst_ready_low", {31'd0, o_ready}, 32'd0);
        chk("rst_valid_low", {31'd0, o_valid}, 32'd0);
        reset = 1'b0;
        step();
        chk("rel_ready", {31'd0, o_ready}, 32'd1);
        chk("rel_valid", {31'd0, o_valid}, 32'd0);
        chk("rel_count", {29'd0, o_count}, 32'd0);
        chk("rel_data",  {24'd0, o_data},  32'd0);
        chk("rel_afull", {31'd0, o_afull}, 32'd0);

        // Fill to full with consumer stalled
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = fill_data[i];
            exp_q.push_back(fill_data[i]);
            step();
            chk("fill_count", {29'd0, o_count}, {29'd0, fill_cnt[i]});
            chk("fill_afull", {31'd0, o_afull}, {31'd0, fill_af[i]});
        end
        chk("full_ready_low", {31'd0, o_ready}, 32'd0);
        i_data = 8'h55;
        step();
        chk("full_refuse_count", {29'd0, o_count}, 32'd4);

        // Full with push and pop together: no bypass
        i_ready = 1'b1;
        step();
        chk("nobypass_count", {29'd0, o_count}, 32'd3);
        i_ready = 1'b0;
        exp_q.push_back(8'h55);
        step();
        chk("accept_55_count", {29'd0, o_count}, 32'd4);
        drain();

        // Stream with random back-pressure
        for (int i = 0; i < 10; i++) begin
            bit acc;
            int tries;
            acc   = 1'b0;
            tries = 0;
            i_valid = 1'b1;
            i_data  = 8'(i);
            while (!acc && tries < 50) begin
                i_ready = 1'($urandom_range(0, 1));
                acc = o_ready;
                step();
                if (acc) exp_q.push_back(8'(i));
                tries++;
            end
            if (!acc) begin
                n_checks++;
                n_errors++;
                $display("FAIL stream_accept: word %0d not accepted within 50 cycles", i);
            end
        end
        drain();

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_data  = 8'hA1 + 8'(i);
            exp_q.push_back(i_data);
            step();
        end
        i_flush = 1'b1;
        i_data  = 8'hAA;
        step();
        exp_q.delete();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_count", {29'd0, o_count}, 32'd0);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        chk("flush_ready", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_data  = 8'hB1;
        exp_q.push_back(8'hB1);
        step();
        drain();

        // Asynchronous reset with two words stored
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1;
            i_data  = 8'hC1 + 8'(i);
            exp_q.push_back(i_data);
            step();
        end
        i_valid = 1'b0;
        chk("pre_rst_count", {29'd0, o_count}, 32'd2);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("async_rst_count", {29'd0, o_count}, 32'd0);
        chk("async_rst_ready", {31'd0, o_ready}, 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        chk("rel2_ready", {31'd0, o_ready}, 32'd1);
        chk("rel2_valid", {31'd0, o_valid}, 32'd0);

`ifdef PIPE_PAL_FIFO_PARITY_EN
        i_valid = 1'b1;
        i_data  = 8'h0F;
        exp_q.push_back(8'h0F);
        step();
        i_data        = 8'hF0;
        i_perr_inject = 1'b1;
        exp_q.push_back(8'hF0);
        step();
        i_valid       = 1'b0;
        i_perr_inject = 1'b0;
        chk("perr_clean_head", {31'd0, o_perr}, 32'd0);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("perr_bad_head", {31'd0, o_perr}, 32'd1);
        drain();
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
